// File: rtl/abro_pkg.sv
// abro_pkg
// Shared definitions for the ABRO front end and the ABRO FSM.
//   DEFAULT_SYNC_STAGES / DEFAULT_DEBOUNCE_CYCLES : parameter defaults
//   S0..S3 : one-hot ABRO FSM states, also used by the FSM's bench
//   cnt_width() : debounce counter width, never below 1 bit
package abro_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  localparam logic [3:0] S0 = 4'b0001;
  localparam logic [3:0] S1 = 4'b0010;
  localparam logic [3:0] S2 = 4'b0100;
  localparam logic [3:0] S3 = 4'b1000;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/abro_debounce_chan.sv
// abro_debounce_chan
// One input channel: SYNC_STAGES-deep synchroniser, debounce counter and
// debounced state. Optional rising-edge pulse output under the macro
// ABRO_INPUT_PULSE_EN (undefined: o_level is the debounced level).
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   i_raw      : raw asynchronous input line
//   o_level    : conditioned output (level, or one-cycle pulse under the macro)
//   o_settling : high while the debounce counter is nonzero
module abro_debounce_chan
  import abro_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_settling
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   r_deb;
  logic [CW-1:0]          r_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // The counter only runs while the synchronised value disagrees with the
  // debounced state; any agreement restarts the qualification window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else if (w_s == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_deb <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_settling = (r_cnt != '0);

`ifdef ABRO_INPUT_PULSE_EN
  logic r_deb_d;
  logic r_pulse;

  // History clears to 0 so a line already high at reset release still
  // produces one pulse once it has been debounced.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_d <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      r_pulse <= r_deb & ~r_deb_d;
    end
  end

  assign o_level = r_pulse;
`else
  assign o_level = r_deb;
`endif

endmodule

// File: rtl/abro_input_conditioner.sv
// abro_input_conditioner
// Conditions the two raw ABRO button lines into clean A and B for the FSM.
// Optional macro ABRO_INPUT_PULSE_EN turns A/B into one-cycle rising-edge
// pulses; default build gives debounced levels.
// Ports:
//   clk      : system clock, shared with the FSM
//   reset    : synchronous, active-high reset
//   a_raw    : raw asynchronous A line
//   b_raw    : raw asynchronous B line
//   A        : conditioned A
//   B        : conditioned B
//   settling : high while either debounce counter is nonzero
module abro_input_conditioner
  import abro_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic A,
  output logic B,
  output logic settling
);

  logic w_settling_a;
  logic w_settling_b;

  abro_debounce_chan #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk        (clk),
    .reset      (reset),
    .i_raw      (a_raw),
    .o_level    (A),
    .o_settling (w_settling_a)
  );

  abro_debounce_chan #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk        (clk),
    .reset      (reset),
    .i_raw      (b_raw),
    .o_level    (B),
    .o_settling (w_settling_b)
  );

  assign settling = w_settling_a | w_settling_b;

endmodule
